// File: rtl/alu_pkg.sv
// Shared ALU writeback definitions: default operand width, status flag bit
// positions and the writeback FSM state encoding.
package alu_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int FLAG_W        = 5;

  // Status register layout [S Z N V C]
  localparam int FLAG_S = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback stage: retires ALU results into the register file (one or two
// words) and the status register. Optional macro WB_ZERO_REG_EN protects r0.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int REG_ADDR_W = 5
) (
  input  logic                   clkout,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*DATA_SIZE-1:0] in_result,
  input  logic [FLAG_W-1:0]      in_flags,
  input  logic [REG_ADDR_W-1:0]  in_rd,
  input  logic                   in_wide,
  input  logic                   in_wb_en,
  input  logic                   in_flag_we,
  output logic                   rf_we,
  output logic [REG_ADDR_W-1:0]  rf_waddr,
  output logic [DATA_SIZE-1:0]   rf_wdata,
  output logic [FLAG_W-1:0]      status,
  output logic [15:0]            retire_cnt
);

`ifdef WB_ZERO_REG_EN
  localparam bit ZERO_REG_PROT = 1'b1;
`else
  localparam bit ZERO_REG_PROT = 1'b0;
`endif

  wb_state_t             state;
  logic [DATA_SIZE-1:0]  hi_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wide_q;
  logic                  accept;
  logic [REG_ADDR_W-1:0] hi_addr;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign hi_addr  = rd_q + 1'b1;

  // A suppressed write leaves rf_waddr/rf_wdata untouched, like any idle cycle.
  function automatic logic write_allowed(input logic [REG_ADDR_W-1:0] addr);
    return !(ZERO_REG_PROT && (addr == '0));
  endfunction

  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      status     <= '0;
      retire_cnt <= '0;
      hi_q       <= '0;
      rd_q       <= '0;
      wide_q     <= 1'b0;
    end else begin
      if (accept) begin
        retire_cnt <= retire_cnt + 16'd1;
        if (in_flag_we)
          status <= in_flags;
      end

      // The low word goes out straight from the accept; only the high word waits.
      case (state)
        IDLE: begin
          rf_we <= 1'b0;
          if (accept && in_wb_en) begin
            state  <= WR_LO;
            hi_q   <= in_result[2*DATA_SIZE-1:DATA_SIZE];
            rd_q   <= in_rd;
            wide_q <= in_wide;
            rf_we  <= write_allowed(in_rd);
            if (write_allowed(in_rd)) begin
              rf_waddr <= in_rd;
              rf_wdata <= in_result[DATA_SIZE-1:0];
            end
          end
        end
        WR_LO: begin
          if (wide_q) begin
            state <= WR_HI;
            rf_we <= write_allowed(hi_addr);
            if (write_allowed(hi_addr)) begin
              rf_waddr <= hi_addr;
              rf_wdata <= hi_q;
            end
          end else begin
            state <= IDLE;
            rf_we <= 1'b0;
          end
        end
        WR_HI: begin
          state <= IDLE;
          rf_we <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, ALU operand width; result bus is 2*DATA_SIZE.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state on rising edge of clkout.
REQ-004 clkout  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  ALU output valid.
REQ-007 in_ready  out  1  stage can accept.
REQ-008 in_result  in  2*DATA_SIZE  ALU result.
REQ-009 in_flags  in  5  ALU flags [S Z N V C] (bit4..bit0).
REQ-010 in_rd  in  REG_ADDR_W  destination register.
REQ-011 in_wide  in  1  write high word too (MUL).
REQ-012 in_wb_en  in  1  write result to register file (0 for COMP/COMPi).
REQ-013 in_flag_we  in  1  update status register.
REQ-014 rf_we  out  1  register-file write strobe.
REQ-015 rf_waddr  out  REG_ADDR_W  write address.
REQ-016 rf_wdata  out  DATA_SIZE  write data.
REQ-017 status  out  5  architectural status register [S Z N V C].
REQ-018 retire_cnt  out  16  count of accepted operations.

Function
REQ-019 SHALL implement FSM states IDLE, WR_LO, WR_HI; in_ready = (state==IDLE).
REQ-020 Accept = in_valid && in_ready at a rising edge; SHALL capture in_result, in_rd, in_wide at accept.
REQ-021 Accept with in_wb_en=1: IDLE->WR_LO; during WR_LO rf_we=1, rf_waddr=in_rd, rf_wdata=result[DATA_SIZE-1:0] (one cycle after accept).
REQ-022 WR_LO with in_wide=1 SHALL go to WR_HI: rf_we=1, rf_waddr=in_rd+1 modulo 2^REG_ADDR_W (wraps), rf_wdata=result[2*DATA_SIZE-1:DATA_SIZE]; then IDLE.
REQ-023 WR_LO with in_wide=0 SHALL return to IDLE; back-to-back accepts therefore occur every 2 cycles (narrow) or 3 cycles (wide).
REQ-024 Accept with in_wb_en=0: no register write, state stays IDLE, in_ready stays 1.
REQ-025 status SHALL load in_flags at the accept edge when in_flag_we=1, else hold; independent of in_wb_en.
REQ-026 rf_we SHALL be 0 in IDLE; rf_waddr/rf_wdata hold last values when rf_we=0.
REQ-027 retire_cnt SHALL increment by 1 per accept, wrapping 0xFFFF->0x0000.
REQ-028 in_valid while in_ready=0 SHALL be ignored; upstream holds data.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, status=5'b00000, retire_cnt=0; in_ready=1.
REQ-030 Reset during WR_LO/WR_HI SHALL abandon pending writes; no write after release until a new accept.

Configuration
REQ-031 Macro WB_ZERO_REG_EN: when defined, a write whose address is 0 SHALL have rf_we forced 0 (FSM timing unchanged; high word to register 1 still written); when undefined, register 0 is writable.

Structure
REQ-032 Shared package alu_pkg SHALL hold DATA_SIZE default, flag bit indices (S=4,Z=3,N=2,V=1,C=0) and the writeback state enum.
REQ-033 Single module; no sub-module.

Verification
REQ-034 Reset, then in_valid=1, in_result=64'h0000_0000_0000_0005, in_rd=3, in_wb_en=1, in_wide=0 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=32'h5; in_ready=0 that cycle; retire_cnt=1.
REQ-035 MUL: in_result=64'h0000_0001_FFFF_FFFE, in_rd=31, in_wide=1 -> writes 32'hFFFF_FFFE to r31, then 32'h1 to r0 (wrap).
REQ-036 COMP: in_wb_en=0, in_flag_we=1, in_flags=5'b01000 -> no rf_we, status=5'b01000 after edge, in_ready stays 1.
REQ-037 Assert rst_n=0 mid WR_LO of a wide op -> rf_we=0 immediately, no WR_HI write after release, status=0.
REQ-038 WB_ZERO_REG_EN defined, in_rd=0, in_result=64'h7 -> rf_we stays 0; undefined -> rf_we=1, rf_waddr=0.
